// File: rtl/uart_tx_cfg_if.sv
// Upstream-facing handshake bundle of the configurable UART transmitter:
// word request/accept plus the serial line and completion pulse.
interface uart_tx_cfg_if #(
  parameter int unsigned D_BIT = 8
);
  logic             tx_start;
  logic [D_BIT-1:0] d_in;
  logic             tx_ready;
  logic             tx_busy;
  logic             tx;
  logic             tx_done_tick;

  modport master (
    output tx_start, d_in,
    input  tx_ready, tx_busy, tx, tx_done_tick
  );

  modport slave (
    input  tx_start, d_in,
    output tx_ready, tx_busy, tx, tx_done_tick
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable data bits, optional even/odd parity and
// stop length, paced by an external oversampling tick.
module uart_tx_cfg #(
  parameter int unsigned D_BIT   = 8,
  parameter int unsigned OS_TICK = 16,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PARITY  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  uart_tx_cfg_if.slave    bus
);

  localparam int unsigned TICK_MAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
  localparam int unsigned TW       = $clog2(TICK_MAX);
  localparam int unsigned BW       = $clog2(D_BIT);
  localparam logic [TW-1:0] OS_LAST  = TW'(OS_TICK - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(D_BIT - 1);
  localparam bit PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_INIT = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e           state_q;
  logic [TW-1:0]    tick_q;
  logic [BW-1:0]    bit_q;
  logic [D_BIT-1:0] shreg_q;
  logic             par_q;
  logic             tx_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (bus.tx_start) begin
            shreg_q <= bus.d_in;
            tick_q  <= '0;
            par_q   <= PAR_INIT;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shreg_q[0];
            state_q <= DATA;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        DATA: if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_q  <= '0;
            par_q   <= par_q ^ shreg_q[0];
            shreg_q <= shreg_q >> 1;
            if (bit_q == BIT_LAST) begin
              // tx is registered, so the next bit value is computed ahead of the shift
              if (PAR_EN) begin
                tx_q    <= par_q ^ shreg_q[0];
                state_q <= PAR;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              bit_q <= bit_q + BW'(1);
              tx_q  <= shreg_q[1];
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        PAR: if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        STOP: if (s_tick) begin
          if (tick_q == SB_LAST) begin
            tick_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_done_tick = done_q;
  assign bus.tx_ready     = (state_q == IDLE);
  assign bus.tx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboarded bench for uart_tx_cfg: four frame formats, each frame checked
// clock-by-clock against a waveform built from hand-given bits and parity.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tick;
  logic       start_r = 1'b0;
  logic [7:0] d_r = '0;
  int         sel = 0;
  int         tick_div = 1;
  int         tick_cnt = 0;
  bit         mon_en = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int cyc = 0;
  int done_cyc[$];

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          bitclk;
    int          stopclk;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) tick_cnt <= (tick_cnt >= tick_div - 1) ? 0 : tick_cnt + 1;
  assign s_tick = (tick_cnt == tick_div - 1);

  uart_tx_cfg_if #(.D_BIT(8)) if8 ();
  uart_tx_cfg_if #(.D_BIT(8)) ife ();
  uart_tx_cfg_if #(.D_BIT(8)) ifo ();
  uart_tx_cfg_if #(.D_BIT(5)) if5 ();

  assign if8.tx_start = start_r && (sel == 0);
  assign ife.tx_start = start_r && (sel == 1);
  assign ifo.tx_start = start_r && (sel == 2);
  assign if5.tx_start = start_r && (sel == 3);
  assign if8.d_in = d_r;
  assign ife.d_in = d_r;
  assign ifo.d_in = d_r;
  assign if5.d_in = d_r[4:0];

  uart_tx_cfg #(.D_BIT(8), .OS_TICK(16), .SB_TICK(16), .PARITY(0))
    u8 (.clk(clk), .rst(rst), .s_tick(s_tick), .bus(if8));
  uart_tx_cfg #(.D_BIT(8), .OS_TICK(16), .SB_TICK(16), .PARITY(1))
    ue (.clk(clk), .rst(rst), .s_tick(s_tick), .bus(ife));
  uart_tx_cfg #(.D_BIT(8), .OS_TICK(16), .SB_TICK(16), .PARITY(2))
    uo (.clk(clk), .rst(rst), .s_tick(s_tick), .bus(ifo));
  uart_tx_cfg #(.D_BIT(5), .OS_TICK(16), .SB_TICK(32), .PARITY(0))
    u5 (.clk(clk), .rst(rst), .s_tick(s_tick), .bus(if5));

  logic m_tx, m_done, m_ready, m_busy;
  always_comb begin
    m_tx = 1'b1; m_done = 1'b0; m_ready = 1'b0; m_busy = 1'b0;
    case (sel)
      0: begin m_tx = if8.tx; m_done = if8.tx_done_tick; m_ready = if8.tx_ready; m_busy = if8.tx_busy; end
      1: begin m_tx = ife.tx; m_done = ife.tx_done_tick; m_ready = ife.tx_ready; m_busy = ife.tx_busy; end
      2: begin m_tx = ifo.tx; m_done = ifo.tx_done_tick; m_ready = ifo.tx_ready; m_busy = ifo.tx_busy; end
      default: begin m_tx = if5.tx; m_done = if5.tx_done_tick; m_ready = if5.tx_ready; m_busy = if5.tx_busy; end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int dbits,
                                             input bit has_par, input logic pbit);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < dbits; i++) b[1+i] = d[i];
    if (has_par) b[1+dbits] = pbit;
    return b;
  endfunction

  task automatic expect_frame(input logic [7:0] d, input int dbits, input bit has_par,
                              input logic pbit, input int div, input int sb);
    exp_t e;
    e.bits    = frame_bits(d, dbits, has_par, pbit);
    e.nbits   = 1 + dbits + (has_par ? 1 : 0);
    e.bitclk  = 16 * div;
    e.stopclk = sb * div;
    exp_q.push_back(e);
  endtask

  // One-cycle start pulse, aligned so the accepting edge carries an s_tick.
  task automatic pulse_start(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_tick && n < 100) begin @(negedge clk); n++; end
    d_r = d;
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin @(negedge clk); n++; end
    if (done_cnt < target) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got %0d done pulses, expected %0d", name, done_cnt, target);
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc.push_back(cyc);
    end
  end

  initial begin : monitor
    logic prev;
    exp_t e;
    int   total, bad_wave, bad_busy, bad_done;
    logic exp_tx;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !m_tx && mon_en) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_frame: got a start bit, expected none");
        end else begin
          e = exp_q.pop_front();
          total = e.nbits * e.bitclk + e.stopclk;
          bad_wave = 0; bad_busy = 0; bad_done = 0;
          for (int c = 0; c < total; c++) begin
            if (c > 0) @(negedge clk);
            exp_tx = (c < e.nbits * e.bitclk) ? e.bits[c / e.bitclk] : 1'b1;
            if (m_tx !== exp_tx) bad_wave++;
            if (m_busy !== 1'b1) bad_busy++;
            if (m_done !== 1'b0) bad_done++;
          end
          @(negedge clk);
          check("frame_waveform_bad_cycles", bad_wave, 0);
          check("frame_busy_bad_cycles", bad_busy, 0);
          check("frame_early_done_cycles", bad_done, 0);
          check("frame_done_ready_tx", {m_done, m_ready, m_tx}, 3'b111);
        end
      end
      prev = m_tx;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("rst_8n1", {if8.tx, if8.tx_ready, if8.tx_busy, if8.tx_done_tick}, 4'b1100);
    check("rst_even", {ife.tx, ife.tx_ready, ife.tx_busy, ife.tx_done_tick}, 4'b1100);
    check("rst_odd", {ifo.tx, ifo.tx_ready, ifo.tx_busy, ifo.tx_done_tick}, 4'b1100);
    check("rst_5d2s", {if5.tx, if5.tx_ready, if5.tx_busy, if5.tx_done_tick}, 4'b1100);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 0x55, with an ignored start request while busy
    sel = 0;
    expect_frame(8'h55, 8, 0, 1'b0, 1, 16);
    pulse_start(8'h55);
    repeat (40) @(negedge clk);
    d_r = 8'hFF; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    wait_done(1, 400, "8n1");
    repeat (200) @(negedge clk);
    check("busy_start_ignored_done_count", done_cnt, 1);

    // Even then odd parity
    sel = 1;
    expect_frame(8'h07, 8, 1, 1'b1, 1, 16); pulse_start(8'h07); wait_done(2, 400, "even07");
    expect_frame(8'h00, 8, 1, 1'b0, 1, 16); pulse_start(8'h00); wait_done(3, 400, "even00");
    sel = 2;
    expect_frame(8'h07, 8, 1, 1'b0, 1, 16); pulse_start(8'h07); wait_done(4, 400, "odd07");
    expect_frame(8'h00, 8, 1, 1'b1, 1, 16); pulse_start(8'h00); wait_done(5, 400, "odd00");

    // 5 data bits, 2 stop, s_tick every 4th clk
    sel = 3;
    tick_div = 4;
    expect_frame(8'h13, 5, 0, 1'b0, 4, 32); pulse_start(8'h13); wait_done(6, 1500, "5d2s");
    tick_div = 1;
    repeat (4) @(negedge clk);

    // Back-to-back with tx_start held high, d_in changed mid-frame
    sel = 0;
    base = done_cnt;
    expect_frame(8'hA5, 8, 0, 1'b0, 1, 16);
    expect_frame(8'hA5, 8, 0, 1'b0, 1, 16);
    expect_frame(8'h3C, 8, 0, 1'b0, 1, 16);
    d_r = 8'hA5; start_r = 1'b1;
    wait_done(base + 1, 400, "b2b_1");
    repeat (50) @(negedge clk);
    d_r = 8'h3C;
    wait_done(base + 2, 400, "b2b_2");
    start_r = 1'b0;
    wait_done(base + 3, 400, "b2b_3");
    repeat (200) @(negedge clk);
    check("b2b_done_count", done_cnt - base, 3);
    if (done_cyc.size() >= 3)
      check("b2b_span_cycles", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-3], 322);

    // Reset during DATA bit 3 abandons the frame
    mon_en = 1'b0;
    base = done_cnt;
    pulse_start(8'hF0);
    repeat (70) @(negedge clk);
    check("pre_rst_busy", if8.tx_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_tx_ready_busy", {if8.tx, if8.tx_ready, if8.tx_busy}, 3'b110);
    repeat (300) @(negedge clk);
    check("rst_mid_no_done", done_cnt - base, 0);
    mon_en = 1'b1;
    expect_frame(8'h81, 8, 0, 1'b0, 1, 16);
    pulse_start(8'h81);
    wait_done(base + 1, 400, "after_rst_81");

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter with a configurable frame format: 5–9 data bits, optional even or odd parity, and 1, 1.5 or 2 stop bits.
It is driven by the shared baud-rate oversampling tick (s_tick) and takes bytes from the upstream FIFO or controller over a ready/start handshake.
It drives the serial line with a registered, glitch-free output and flags frame completion with a one-cycle pulse.

Parameters:
D_BIT, 8, data bits per frame; legal 5..9.
OS_TICK, 16, s_tick pulses per start/data/parity bit; legal 8..32.
SB_TICK, 16, s_tick pulses in the stop period; 16 = 1 stop, 24 = 1.5 stop, 32 = 2 stop (for OS_TICK=16); legal 1..64.
PARITY, 0, 0 = none, 1 = even, 2 = odd; 3 is illegal (treated as none).

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
s_tick  in  1  oversampling enable pulse, one clk wide.
tx_start  in  1  request to send d_in; honoured only while tx_ready=1.
d_in  in  D_BIT  data word; sampled on the accepting edge only.
tx_ready  out  1  high in IDLE, i.e. a new word can be accepted.
tx_busy  out  1  inverse of tx_ready.
tx  out  1  serial line, registered; idle level 1.
tx_done_tick  out  1  one-clk pulse marking frame completion.

Behaviour:
- Reset (synchronous, wins over all other inputs):
  - state=IDLE, tx=1, tx_done_tick=0, tx_ready=1, tx_busy=0.
  - Tick and bit counters and the shift register are cleared.
  - Reset mid-frame abandons the frame; tx returns to 1 at that same edge; no tx_done_tick is produced.
- States are IDLE, START, DATA, PAR, STOP. Counters:
  - tick counter wide enough for max(OS_TICK, SB_TICK)-1;
  - bit counter of clog2(D_BIT) bits;
  - shift register D_BIT wide;
  - parity accumulator 1 bit.
- IDLE:
  - tx=1.
  - Accept when tx_start=1 at an edge: latch d_in, clear the tick counter, set the parity accumulator to 0 (even) or 1 (odd), go to START, register tx=0.
  - tx goes low in the cycle after tx_start is sampled.
  - Changes to d_in after acceptance have no effect.
- START:
  - tx=0; the tick counter increments on each s_tick.
  - On the s_tick with count = OS_TICK-1: clear the counter, bit counter=0, go to DATA, tx<=bit0.
- DATA:
  - tx = shift register LSB; LSB first.
  - On the s_tick with count = OS_TICK-1: XOR the sent bit into the parity accumulator, shift right, clear the counter.
  - If bit counter = D_BIT-1: go to PAR if PARITY is 1 or 2, otherwise go to STOP. Else increment the bit counter.
- PAR:
  - tx = parity accumulator. Even parity makes the total count of 1s (data + parity) even; odd parity makes it odd.
  - On the s_tick with count = OS_TICK-1: go to STOP.
- STOP:
  - tx=1.
  - On the s_tick with count = SB_TICK-1: go to IDLE and register tx_done_tick=1 for exactly one clk, coincident with the first IDLE cycle (tx_ready=1 in that cycle).
- s_tick=0 holds all counters and state. tx changes only on tick-boundary edges or on accept.
- Frame length = OS_TICK*(1+D_BIT+P)+SB_TICK s_ticks, where P=1 if parity is enabled.
- tx_start while busy is ignored and not queued.
- Back-to-back frames: tx_start=1 in the tx_done_tick cycle is accepted, so tx falls in the next cycle. The line is never held idle-high longer than one clk between frames.
- tx_ready and tx_busy are decoded from the registered state; no combinational path from tx_start.

Test Plan:
- 8N1, OS_TICK=16, s_tick every clk, d_in=0x55, tx_start one cycle → tx: 16 clk low, then 1,0,1,0,1,0,1,0 at 16 clk each, then 16 clk high. tx_done_tick pulses once, 160 clk after tx falls. tx_busy is high throughout.
- PARITY=1, d_in=0x07 → parity bit=1; PARITY=2, d_in=0x07 → parity bit=0. Same checks with d_in=0x00 give 0 (even) and 1 (odd). Frame length is 176 ticks.
- D_BIT=5, SB_TICK=32, d_in=5'h13 → bits 1,1,0,0,1 then 32 ticks high. Run with s_tick every 4th clk; every bit lasts exactly 64 clk.
- Send 0xA5 with tx_start held high continuously → 0xA5 is re-sent back-to-back. Mid-frame changes of d_in (0xA5→0x3C) do not alter the current frame. Exactly one tx_done_tick per frame.
- Assert rst for one clk during DATA bit 3 → tx=1 in the next cycle, tx_ready=1, no tx_done_tick. A following send of 0x81 transmits correctly.
